if_fetch: RTL and testbench

Instruction-fetch stage directly upstream of the decode stage. It owns the fetch PC and issues one instruction read at a time over a req/ack memory port. It presents {pc_o, inst_o, inst_valid_o} as the IF/ID pipeline register. It holds that register under stall, redirects on a taken branch/jump from decode, and discards any in-flight fetch made stale by the redirect.

---
 rtl/if_fetch_pkg.sv | 27 ++
 rtl/if_skid_buf.sv | 44 ++++
 rtl/if_fetch.sv | 154 +++++++++++++++
 tb/tb_if_fetch.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_pkg: shared definitions for the instruction-fetch stage.
//   - fetch_state_t : fetch FSM state encodings (IDLE / WAIT / DISCARD)
//   - OP_* / FUNCT3_* : RV32I opcode and funct3 fields used by this stage
//   - NOP_INST_DEFAULT, RESET_PC_DEFAULT : default bubble word and boot PC
//   - align_word() : force an address onto a 4-byte instruction boundary
// ---------------------------------------------------------------------------
package if_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_WAIT    = 2'd1,
    FETCH_DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [2:0] FUNCT3_ADDI = 3'b000;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST_DEFAULT = {12'h000, 5'd0, FUNCT3_ADDI, 5'd0, OP_IMM};
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// ---------------------------------------------------------------------------
// if_skid_buf: one-entry {pc, inst} holding slot for a fetched word that
// arrives while the IF/ID register is occupied and stalled.
//   clk, rst          : clock, synchronous active-high reset
//   push, push_pc/inst: capture a word (slot becomes full)
//   pop               : slot has been consumed (slot becomes empty)
//   flush             : discard contents (wins over push/pop)
//   full, pc, inst    : slot status and contents
// ---------------------------------------------------------------------------
module if_skid_buf
  import if_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_inst,
  output logic        full,
  output logic [31:0] pc,
  output logic [31:0] inst
);

  // Slot occupancy and payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      pc   <= 32'h0000_0000;
      inst <= 32'h0000_0000;
    end else if (flush) begin
      full <= 1'b0;
    end else if (push) begin
      full <= 1'b1;
      pc   <= push_pc;
      inst <= push_inst;
    end else if (pop) begin
      full <= 1'b0;
    end else begin
      full <= full;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch: instruction-fetch stage feeding decode through the IF/ID register.
// Issues one req/ack memory read at a time, holds IF/ID under stall (spilling
// one returning word into a skid slot), and redirects on a taken branch,
// discarding any in-flight fetch made stale by the redirect.
//   clk, rst                 : clock, synchronous active-high reset
//   stall_i                  : decode stalled, hold IF/ID
//   branch_i, branch_addr_i  : redirect request and target
//   mem_req_o, mem_addr_o    : fetch request (held until ack) and address
//   mem_ack_i, mem_rdata_i   : one-cycle ack pulse with instruction word
//   pc_o, inst_o, inst_valid_o : IF/ID register
// ---------------------------------------------------------------------------
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  fetch_state_t state;
  logic [31:0]  fetch_pc;
  logic [31:0]  target;
  logic         redirect;
  logic         take_ack;
  logic         reg_free;
  logic         skid_push;
  logic         skid_pop;
  logic         skid_full;
  logic [31:0]  skid_pc;
  logic [31:0]  skid_inst;

  // A branch only counts when decode actually holds a real, advancing instruction.
  assign redirect  = branch_i & inst_valid_o & ~stall_i;
  assign target    = align_word(branch_addr_i);
  // Only an ack for a live (WAIT) request carries usable data; redirect kills it.
  assign take_ack  = (state == FETCH_WAIT) & mem_ack_i & ~redirect;
  assign reg_free  = ~inst_valid_o | ~stall_i;
  assign skid_push = take_ack & ~reg_free;
  assign skid_pop  = skid_full & ~stall_i & ~redirect;

  assign mem_addr_o = fetch_pc;

  if_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (skid_push),
    .pop       (skid_pop),
    .flush     (redirect),
    .push_pc   (fetch_pc),
    .push_inst (mem_rdata_i),
    .full      (skid_full),
    .pc        (skid_pc),
    .inst      (skid_inst)
  );

  // Fetch FSM: owns fetch_pc and the registered request strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH_IDLE;
      fetch_pc  <= RESET_PC;
      mem_req_o <= 1'b0;
    end else begin
      case (state)
        FETCH_IDLE: begin
          if (redirect) begin
            fetch_pc <= target;
          end else if (!skid_full) begin
            state     <= FETCH_WAIT;
            mem_req_o <= 1'b1;
          end else begin
            state <= FETCH_IDLE;
          end
        end
        FETCH_WAIT: begin
          if (redirect) begin
            fetch_pc <= target;
            // Same-cycle ack is simply dropped; otherwise wait it out.
            if (mem_ack_i) begin
              state     <= FETCH_IDLE;
              mem_req_o <= 1'b0;
            end else begin
              state <= FETCH_DISCARD;
            end
          end else if (mem_ack_i) begin
            fetch_pc  <= fetch_pc + 32'd4;
            state     <= FETCH_IDLE;
            mem_req_o <= 1'b0;
          end else begin
            state <= FETCH_WAIT;
          end
        end
        FETCH_DISCARD: begin
          if (redirect) begin
            fetch_pc <= target;
          end
          if (mem_ack_i) begin
            state     <= FETCH_IDLE;
            mem_req_o <= 1'b0;
          end
        end
        default: begin
          state     <= FETCH_IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

  // IF/ID pipeline register: redirect flush > skid drain > ack load > bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_o         <= 32'h0000_0000;
      inst_o       <= NOP_INST;
      inst_valid_o <= 1'b0;
    end else if (redirect) begin
      inst_o       <= NOP_INST;
      inst_valid_o <= 1'b0;
    end else if (!stall_i) begin
      if (skid_full) begin
        pc_o         <= skid_pc;
        inst_o       <= skid_inst;
        inst_valid_o <= 1'b1;
      end else if (take_ack) begin
        pc_o         <= fetch_pc;
        inst_o       <= mem_rdata_i;
        inst_valid_o <= 1'b1;
      end else begin
        inst_o       <= NOP_INST;
        inst_valid_o <= 1'b0;
      end
    end else if (take_ack && !inst_valid_o) begin
      // Stalled but empty: the register is free, so no need to use the skid.
      pc_o         <= fetch_pc;
      inst_o       <= mem_rdata_i;
      inst_valid_o <= 1'b1;
    end else begin
      inst_valid_o <= inst_valid_o;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch: self-checking bench for if_fetch. A queue-based model treats
// IF/ID plus skid as a 2-deep FIFO of fetched words in program order and
// tracks the single outstanding request; it is compared every cycle.
// Directed sequences pin the model with hand-computed literals, then a
// randomized phase exercises stall/branch/latency/reset mixes.
// ---------------------------------------------------------------------------
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  if_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .branch_i      (branch_i),
    .branch_addr_i (branch_addr_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .mem_rdata_i   (mem_rdata_i),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .inst_valid_o  (inst_valid_o)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  int checks = 0;
  int errors = 0;

  // Model state
  ent_t        mq[$];
  bit          m_out;
  bit          m_stale;
  logic [31:0] m_pc;

  // Stimulus intent and memory responder state
  bit          rst_v, stall_v, branch_v;
  logic [31:0] baddr_v;
  int          lat_cfg;
  bit          resp_act;
  int          resp_cnt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_A5A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("mem_req", {31'd0, mem_req_o}, {31'd0, m_out});
    chk("mem_addr", mem_addr_o, m_pc);
    chk("inst_valid", {31'd0, inst_valid_o}, (mq.size() > 0) ? 32'd1 : 32'd0);
    if (mq.size() > 0) begin
      chk("pc_o", pc_o, mq[0].pc);
      chk("inst_o", inst_o, mq[0].inst);
    end else begin
      chk("inst_nop", inst_o, NOP);
    end
  endtask

  task automatic model_step(input bit r, input bit st, input bit br,
                            input logic [31:0] ba, input bit ak);
    bit valid, redir, nxt_out;
    if (r) begin
      mq.delete();
      m_out   = 1'b0;
      m_stale = 1'b0;
      m_pc    = 32'h0;
    end else begin
      valid   = (mq.size() > 0);
      redir   = br && valid && !st;
      nxt_out = m_out ? !ak : ((mq.size() < 2) && !redir);
      if (redir) begin
        mq.delete();
        m_stale = m_out && !ak;
        m_pc    = ba & 32'hFFFF_FFFC;
      end else begin
        if (!st && valid) void'(mq.pop_front());
        if (m_out && ak) begin
          if (!m_stale) begin
            mq.push_back('{pc: m_pc, inst: mem_word(m_pc)});
            m_pc = m_pc + 32'd4;
          end
          m_stale = 1'b0;
        end
      end
      m_out = nxt_out;
    end
  endtask

  // One clock: check, let memory respond, drive inputs, advance model.
  task automatic cycle();
    bit          ak;
    logic [31:0] rd;
    compare();
    ak = 1'b0;
    rd = $urandom;
    if (rst_v) begin
      resp_act = 1'b0;
    end else if (mem_req_o) begin
      if (!resp_act) begin
        resp_act = 1'b1;
        resp_cnt = lat_cfg;
      end
      if (resp_cnt == 0) begin
        ak       = 1'b1;
        rd       = mem_word(mem_addr_o);
        resp_act = 1'b0;
      end else begin
        resp_cnt--;
      end
    end
    rst           = rst_v;
    stall_i       = stall_v;
    branch_i      = branch_v;
    branch_addr_i = baddr_v;
    mem_ack_i     = ak;
    mem_rdata_i   = rd;
    model_step(rst_v, stall_v, branch_v, baddr_v, ak);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; branch_i = 1'b0; branch_addr_i = 32'h0;
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    rst_v = 1'b0; stall_v = 1'b0; branch_v = 1'b0; baddr_v = 32'h0;
    lat_cfg = 0; resp_act = 1'b0; resp_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    // Reset state
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_inst", inst_o, NOP);
    chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);

    // Sequential fetch with 1-cycle-ack memory
    cycles(2);
    chk("first_valid", {31'd0, inst_valid_o}, 32'd1);
    chk("first_pc", pc_o, 32'h0);
    chk("first_inst", inst_o, 32'hA5A5_A5A5);
    cycle();
    chk("bubble_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("second_req", {31'd0, mem_req_o}, 32'd1);
    chk("second_addr", mem_addr_o, 32'h4);
    cycles(7);
    chk("pc10_pc", pc_o, 32'h10);

    // Stall 4 cycles while 0x14 is acked into the skid
    stall_v = 1'b1;
    cycles(4);
    chk("stall_pc", pc_o, 32'h10);
    chk("stall_valid", {31'd0, inst_valid_o}, 32'd1);
    chk("stall_noreq", {31'd0, mem_req_o}, 32'd0);
    chk("stall_addr", mem_addr_o, 32'h18);
    stall_v = 1'b0;
    cycle();
    chk("skid_pc", pc_o, 32'h14);
    chk("skid_inst", inst_o, 32'hA5A5_A5B1);
    cycle();
    chk("resume_addr", mem_addr_o, 32'h18);
    chk("resume_req", {31'd0, mem_req_o}, 32'd1);
    cycles(5);
    chk("pc20_pc", pc_o, 32'h20);

    // Redirect while WAIT for 0x24 (ack two cycles later)
    stall_v = 1'b1; lat_cfg = 2;
    cycle();
    stall_v = 1'b0; branch_v = 1'b1; baddr_v = 32'h103;
    cycle();
    chk("disc_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("disc_addr", mem_addr_o, 32'h100);
    branch_v = 1'b0; lat_cfg = 0;
    cycles(4);
    chk("tgt_pc", pc_o, 32'h100);
    chk("tgt_inst", inst_o, 32'hA5A5_A4A5);

    // Redirect coinciding with ack, to an unaligned address near wrap
    stall_v = 1'b1;
    cycle();
    stall_v = 1'b0; branch_v = 1'b1; baddr_v = 32'hFFFF_FFFE;
    cycle();
    chk("same_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("same_req", {31'd0, mem_req_o}, 32'd0);
    chk("same_addr", mem_addr_o, 32'hFFFF_FFFC);
    branch_v = 1'b0;
    cycles(2);
    chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
    chk("wrap_inst", inst_o, 32'h5A5A_5A59);
    chk("wrap_addr", mem_addr_o, 32'h0);

    // Branch under stall is ignored
    stall_v = 1'b1; branch_v = 1'b1; baddr_v = 32'h500;
    cycle();
    chk("ign_addr", mem_addr_o, 32'h0);
    chk("ign_req", {31'd0, mem_req_o}, 32'd1);

    // Reset mid-WAIT
    stall_v = 1'b0; branch_v = 1'b0; rst_v = 1'b1;
    cycle();
    chk("mrst_req", {31'd0, mem_req_o}, 32'd0);
    chk("mrst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("mrst_inst", inst_o, NOP);
    rst_v = 1'b0;
    cycles(2);
    chk("restart_pc", pc_o, 32'h0);
    chk("restart_valid", {31'd0, inst_valid_o}, 32'd1);

    // Randomized phase against the model
    for (int i = 0; i < 4000; i++) begin
      stall_v  = ($urandom_range(0, 9) < 3);
      branch_v = ($urandom_range(0, 9) < 2);
      baddr_v  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                            : 32'($urandom);
      lat_cfg  = $urandom_range(0, 3);
      rst_v    = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst_v = 1'b0; stall_v = 1'b0; branch_v = 1'b0;
    cycles(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
